// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit: flush, valid/ready request with
// operands and opcode, valid/ready response with result, and busy status.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic [1:0]       divOp;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] port_out;
    logic             busy;

    modport master (
        output flush, req_valid, port_a, port_b, divOp, resp_ready,
        input  req_ready, resp_valid, port_out, busy
    );

    modport slave (
        input  flush, req_valid, port_a, port_b, divOp, resp_ready,
        output req_ready, resp_valid, port_out, busy
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU, one restoring radix-2 step
// per cycle over magnitudes, sign fix-up on the final step.
// Divide-by-zero and signed overflow finish one cycle after acceptance.
// Optional feature macro: DIV_EARLY_OUT_EN (|b|>|a| or |b|==1 finish in one
// cycle as well; results are identical either way).
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic       CLK,
    input logic       nRST,
    div_unit_if.slave bus
);
    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_resp_valid;
    logic             r_req_ready;
    logic             r_busy;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_fast;
    logic [WIDTH-1:0] w_fast_res;

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Operand decode at acceptance: sign flags, magnitudes, special cases
    always_comb begin
        w_signed   = ~bus.divOp[0];
        w_a_neg    = w_signed & bus.port_a[WIDTH-1];
        w_b_neg    = w_signed & bus.port_b[WIDTH-1];
        w_abs_a    = w_a_neg ? (~bus.port_a + 1'b1) : bus.port_a;
        w_abs_b    = w_b_neg ? (~bus.port_b + 1'b1) : bus.port_b;
        w_div_zero = (bus.port_b == '0);
        w_ovf      = w_signed && (bus.port_a == MIN_VAL) && (bus.port_b == '1);
    end

    // One-cycle result for requests that need no iteration
    always_comb begin
        w_fast     = 1'b0;
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast     = 1'b1;
            w_fast_res = bus.divOp[1] ? bus.port_a : '1;
        end else if (w_ovf) begin
            w_fast     = 1'b1;
            w_fast_res = bus.divOp[1] ? '0 : MIN_VAL;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (w_abs_b > w_abs_a) begin
            w_fast     = 1'b1;
            w_fast_res = bus.divOp[1] ? bus.port_a : '0;
        end else if (w_abs_b == WIDTH'(1)) begin
            w_fast     = 1'b1;
            w_fast_res = bus.divOp[1] ? '0 :
                         ((w_a_neg ^ w_b_neg) ? (~w_abs_a + 1'b1) : w_abs_a);
        end
`endif
    end

    // Restoring step: the trial subtract is one bit wider than the remainder
    // so its top bit is the borrow, i.e. the inverse of rem >= |b|
    always_comb begin
        w_shift   = {r_rem, r_quo[WIDTH-1]};
        w_diff    = w_shift - {2'b00, r_div};
        w_ge      = ~w_diff[WIDTH+1];
        w_rem_nxt = w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
        w_q_fix   = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
        w_r_fix   = r_neg_r ? (~w_rem_nxt[WIDTH-1:0] + 1'b1) : w_rem_nxt[WIDTH-1:0];
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_is_rem     <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_div        <= '0;
            r_cnt        <= '0;
            r_out        <= '0;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else if (bus.flush) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_is_rem    <= bus.divOp[1];
                        r_neg_q     <= w_a_neg ^ w_b_neg;
                        r_neg_r     <= w_a_neg;
                        r_div       <= w_abs_b;
                        r_quo       <= w_abs_a;
                        r_rem       <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_fast) begin
                            r_out        <= w_fast_res;
                            r_resp_valid <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_cnt   <= CNTW'(WIDTH);
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNTW'(1)) begin
                        r_out        <= r_is_rem ? w_r_fix : w_q_fix;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.port_out   = r_out;
    assign bus.busy       = r_busy;
endmodule
